// File: rtl/simon_datapath_param.sv
// Simon game datapath, parametrised.
// Holds the recorded pattern sequence, the sequence-length and replay
// counters, difficulty-dependent legality, the LED source mux and a
// playback tick timer. Sequenced by the Simon control FSM.
module simon_datapath_param #(
    parameter int WIDTH  = 4,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int TICKS  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              level,
    input  logic [WIDTH-1:0]  pattern,
    input  logic              new_game,
    input  logic              pat_wr,
    input  logic              rep_clr,
    input  logic              rep_inc,
    input  logic              play_en,
    input  logic [1:0]        led_sel,
    output logic              is_legal,
    output logic              correct_pattern,
    output logic              is_last_element,
    output logic              seq_full,
    output logic              play_tick,
    output logic [ADDR_W:0]   score,
    output logic [WIDTH-1:0]  pattern_leds
);

    localparam int TIMER_W = (TICKS > 1) ? $clog2(TICKS) : 1;

    localparam logic [ADDR_W:0]    LEN_ZERO  = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0]    LEN_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]    LEN_FULL  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0]  REP_ZERO  = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0]  REP_ONE   = ADDR_W'(1);
    localparam logic [TIMER_W-1:0] TMR_ZERO  = {TIMER_W{1'b0}};
    localparam logic [TIMER_W-1:0] TMR_ONE   = TIMER_W'(1);
    localparam logic [TIMER_W-1:0] TMR_LAST  = TIMER_W'(TICKS - 1);
    localparam logic [WIDTH-1:0]   PAT_ZERO  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]   PAT_ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0]   PAT_ALL   = {WIDTH{1'b1}};

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
    function automatic logic onehot_f(input logic [WIDTH-1:0] v);
        return (v != PAT_ZERO) && ((v & (v - PAT_ONE)) == PAT_ZERO);
    endfunction

    logic                 level_r;
    logic [ADDR_W:0]      seq_len_r;
    logic [ADDR_W-1:0]    rep_cnt_r;
    logic [TIMER_W-1:0]   timer_r;
    logic [WIDTH-1:0]     mem_r [DEPTH];

    logic                 legal_s;
    logic                 full_s;
    logic                 write_s;
    logic                 rep_can_inc_s;
    logic [WIDTH-1:0]     mem_rd_s;
    logic [WIDTH-1:0]     score_leds_s;

    // Score shown on the LEDs: seq_len zero-extended or truncated to WIDTH.
    generate
        if (WIDTH > ADDR_W + 1) begin : g_score_ext
            assign score_leds_s = {{(WIDTH-ADDR_W-1){1'b0}}, seq_len_r};
        end else if (WIDTH == ADDR_W + 1) begin : g_score_eq
            assign score_leds_s = seq_len_r;
        end else begin : g_score_trunc
            assign score_leds_s = seq_len_r[WIDTH-1:0];
        end
    endgenerate

    // Legality, full flag, write enable and replay saturation decode.
    always_comb begin
        if (level_r) begin
            legal_s = 1'b1;
        end else begin
            legal_s = onehot_f(pattern);
        end
        full_s   = (seq_len_r == LEN_FULL);
        write_s  = pat_wr && legal_s && !full_s;
        mem_rd_s = mem_r[rep_cnt_r];
        // Replay may only advance while it sits below the last stored entry.
        if (seq_len_r != LEN_ZERO) begin
            rep_can_inc_s = ({1'b0, rep_cnt_r} < (seq_len_r - LEN_ONE));
        end else begin
            rep_can_inc_s = 1'b0;
        end
    end

    // Status outputs derived directly from the current state.
    always_comb begin
        is_legal        = legal_s;
        correct_pattern = (pattern == mem_rd_s);
        seq_full        = full_s;
        score           = seq_len_r;
        play_tick       = play_en && (timer_r == TMR_LAST);
        if (seq_len_r != LEN_ZERO) begin
            is_last_element = ({1'b0, rep_cnt_r} == (seq_len_r - LEN_ONE));
        end else begin
            is_last_element = 1'b0;
        end
    end

    // LED source selection.
    always_comb begin
        case (led_sel)
            2'b00:   pattern_leds = pattern;
            2'b01:   pattern_leds = mem_rd_s;
            2'b10:   pattern_leds = PAT_ALL;
            2'b11:   pattern_leds = score_leds_s;
            default: pattern_leds = PAT_ZERO;
        endcase
    end

    // Latched difficulty level, refreshed only when a new game starts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_r <= 1'b0;
        end else if (new_game) begin
            level_r <= level;
        end else begin
            level_r <= level_r;
        end
    end

    // Sequence length: cleared on new game, grows on each accepted write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seq_len_r <= LEN_ZERO;
        end else if (new_game) begin
            seq_len_r <= LEN_ZERO;
        end else if (write_s) begin
            seq_len_r <= seq_len_r + LEN_ONE;
        end else begin
            seq_len_r <= seq_len_r;
        end
    end

    // Replay pointer: clear beats advance; advance saturates at the last entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rep_cnt_r <= REP_ZERO;
        end else if (new_game || rep_clr) begin
            rep_cnt_r <= REP_ZERO;
        end else if (rep_inc && rep_can_inc_s) begin
            rep_cnt_r <= rep_cnt_r + REP_ONE;
        end else begin
            rep_cnt_r <= rep_cnt_r;
        end
    end

    // Playback timer: counts modulo TICKS while enabled, parked at zero otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer_r <= TMR_ZERO;
        end else if (new_game || !play_en) begin
            timer_r <= TMR_ZERO;
        end else if (timer_r == TMR_LAST) begin
            timer_r <= TMR_ZERO;
        end else begin
            timer_r <= timer_r + TMR_ONE;
        end
    end

    // Pattern memory: appended at the current length, survives new games.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= PAT_ZERO;
            end
        end else if (write_s && !new_game) begin
            mem_r[seq_len_r[ADDR_W-1:0]] <= pattern;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= mem_r[i];
            end
        end
    end

endmodule

// File: tb/tb_simon_datapath_param.sv
// Self-checking bench for simon_datapath_param: directed scenarios plus
// random traffic, compared against a behavioural game model via a queue.
module tb_simon_datapath_param;

    localparam int WIDTH  = 4;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int TICKS  = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              level;
    logic [WIDTH-1:0]  pattern;
    logic              new_game;
    logic              pat_wr;
    logic              rep_clr;
    logic              rep_inc;
    logic              play_en;
    logic [1:0]        led_sel;
    logic              is_legal;
    logic              correct_pattern;
    logic              is_last_element;
    logic              seq_full;
    logic              play_tick;
    logic [ADDR_W:0]   score;
    logic [WIDTH-1:0]  pattern_leds;

    simon_datapath_param #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .TICKS(TICKS)
    ) dut (
        .clk(clk), .reset_n(reset_n), .level(level), .pattern(pattern),
        .new_game(new_game), .pat_wr(pat_wr), .rep_clr(rep_clr),
        .rep_inc(rep_inc), .play_en(play_en), .led_sel(led_sel),
        .is_legal(is_legal), .correct_pattern(correct_pattern),
        .is_last_element(is_last_element), .seq_full(seq_full),
        .play_tick(play_tick), .score(score), .pattern_leds(pattern_leds)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               tag;
        logic             legal;
        logic             correct;
        logic             last;
        logic             full;
        logic             tick;
        logic [ADDR_W:0]  score;
        logic [WIDTH-1:0] leds;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural game model: recorded sequence, its length, replay index,
    // and the number of consecutive enabled playback cycles.
    logic             lvl_m;
    int               len_m;
    int               rep_m;
    int               run_m;
    logic [WIDTH-1:0] mem_m [DEPTH];

    task automatic model_reset();
        lvl_m = 1'b0;
        len_m = 0;
        rep_m = 0;
        run_m = 0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    endtask

    function automatic logic model_legal();
        return lvl_m || ($countones(pattern) == 1);
    endfunction

    function automatic exp_t expect_now(int tag);
        exp_t e;
        e.tag     = tag;
        e.legal   = model_legal();
        e.correct = (pattern == mem_m[rep_m]);
        e.last    = (len_m != 0) && (rep_m == len_m - 1);
        e.full    = (len_m == DEPTH);
        e.tick    = play_en && ((run_m % TICKS) == TICKS - 1);
        e.score   = (ADDR_W+1)'(len_m);
        case (led_sel)
            2'd0:    e.leds = pattern;
            2'd1:    e.leds = mem_m[rep_m];
            2'd2:    e.leds = {WIDTH{1'b1}};
            default: e.leds = WIDTH'(len_m);
        endcase
        return e;
    endfunction

    task automatic model_edge();
        int  old_len;
        logic ok;
        if (!reset_n) begin
            model_reset();
        end else if (new_game) begin
            lvl_m = level;
            len_m = 0;
            rep_m = 0;
            run_m = 0;
        end else begin
            ok      = model_legal();
            old_len = len_m;
            if (pat_wr && ok && len_m < DEPTH) begin
                mem_m[len_m] = pattern;
                len_m++;
            end
            if (rep_clr) rep_m = 0;
            else if (rep_inc && rep_m < old_len - 1) rep_m++;
            run_m = play_en ? run_m + 1 : 0;
        end
    endtask

    // One clock cycle of stimulus: apply inputs, queue the expected response,
    // advance the model at the edge.
    task automatic drive(input int tag, input logic ng, input logic lv,
                         input logic [WIDTH-1:0] pat, input logic wr,
                         input logic clr, input logic inc, input logic pe,
                         input logic [1:0] sel);
        new_game = ng; level = lv; pattern = pat; pat_wr = wr;
        rep_clr = clr; rep_inc = inc; play_en = pe; led_sel = sel;
        exp_q.push_back(expect_now(tag));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Monitor: every sampling point pops one expectation and compares.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({is_legal, correct_pattern, is_last_element, seq_full, play_tick, score, pattern_leds} !==
                    {e.legal, e.correct, e.last, e.full, e.tick, e.score, e.leds}) begin
                    errors++;
                    $display("FAIL step %0d outputs: got legal=%b correct=%b last=%b full=%b tick=%b score=%0d leds=%b, expected legal=%b correct=%b last=%b full=%b tick=%b score=%0d leds=%b",
                             e.tag, is_legal, correct_pattern, is_last_element, seq_full, play_tick, score, pattern_leds,
                             e.legal, e.correct, e.last, e.full, e.tick, e.score, e.leds);
                end
            end
        end
    end

    initial begin : stimulus
        logic pe_r;
        reset_n = 1'b0;
        level = 1'b0; pattern = '0; new_game = 1'b0; pat_wr = 1'b0;
        rep_clr = 1'b0; rep_inc = 1'b0; play_en = 1'b0; led_sel = 2'b00;
        model_reset();
        @(posedge clk);
        #1;
        // Reset state
        drive(0, 0, 0, 4'b0000, 0, 0, 0, 0, 2'b00);
        drive(1, 0, 0, 4'b0100, 0, 0, 0, 0, 2'b11);
        reset_n = 1'b1;

        // Easy-mode legality
        drive(10, 1, 0, 4'b0000, 0, 0, 0, 0, 2'b00);
        drive(11, 0, 0, 4'b0100, 0, 0, 0, 0, 2'b00);
        drive(12, 0, 0, 4'b0110, 0, 0, 0, 0, 2'b00);
        drive(13, 0, 0, 4'b0110, 1, 0, 0, 0, 2'b00);
        drive(14, 0, 0, 4'b0000, 0, 0, 0, 0, 2'b11);

        // Hard-mode record and replay
        drive(20, 1, 1, 4'b0000, 0, 0, 0, 0, 2'b00);
        drive(21, 0, 0, 4'b1111, 1, 0, 0, 0, 2'b00);
        drive(22, 0, 0, 4'b0000, 1, 0, 0, 0, 2'b00);
        drive(23, 0, 0, 4'b0000, 0, 1, 0, 0, 2'b01);
        drive(24, 0, 0, 4'b0000, 0, 0, 1, 0, 2'b01);
        drive(25, 0, 0, 4'b0000, 0, 0, 1, 0, 2'b01);
        drive(26, 0, 0, 4'b0000, 0, 0, 0, 0, 2'b01);

        // Compare against stored entry
        drive(30, 1, 1, 4'b0000, 0, 0, 0, 0, 2'b00);
        drive(31, 0, 0, 4'b1010, 1, 0, 0, 0, 2'b00);
        drive(32, 0, 0, 4'b0011, 1, 1, 0, 0, 2'b00);
        drive(33, 0, 0, 4'b1010, 0, 0, 0, 0, 2'b01);
        drive(34, 0, 0, 4'b0011, 0, 0, 0, 0, 2'b01);

        // Full boundary in easy mode
        drive(40, 1, 0, 4'b0000, 0, 0, 0, 0, 2'b00);
        drive(41, 0, 0, 4'b0001, 1, 0, 0, 0, 2'b11);
        drive(42, 0, 0, 4'b0010, 1, 0, 0, 0, 2'b11);
        drive(43, 0, 0, 4'b0100, 1, 0, 0, 0, 2'b11);
        drive(44, 0, 0, 4'b1000, 1, 0, 0, 0, 2'b11);
        drive(45, 0, 0, 4'b0010, 1, 1, 0, 0, 2'b11);
        drive(46, 0, 0, 4'b0000, 0, 0, 0, 0, 2'b01);
        drive(47, 0, 0, 4'b0000, 0, 0, 1, 0, 2'b01);

        // Playback timer: 12 enabled cycles, then a dropped count
        for (int i = 0; i < 12; i++) drive(50 + i, 0, 0, 4'b0001, 0, 0, 0, 1, 2'b10);
        drive(62, 0, 0, 4'b0001, 0, 0, 0, 0, 2'b10);
        drive(63, 0, 0, 4'b0001, 0, 0, 0, 1, 2'b10);
        drive(64, 0, 0, 4'b0001, 0, 0, 0, 1, 2'b10);
        drive(65, 0, 0, 4'b0001, 0, 0, 0, 0, 2'b10);
        for (int i = 0; i < 4; i++) drive(66 + i, 0, 0, 4'b0001, 0, 0, 0, 1, 2'b10);

        // Priority: new_game over pat_wr, rep_clr over rep_inc
        drive(70, 1, 1, 4'b0101, 1, 0, 0, 0, 2'b11);
        drive(71, 0, 0, 4'b0101, 0, 0, 0, 0, 2'b11);
        drive(72, 0, 0, 4'b0110, 1, 0, 0, 0, 2'b01);
        drive(73, 0, 0, 4'b1001, 1, 0, 1, 0, 2'b01);
        drive(74, 0, 0, 4'b0000, 0, 0, 1, 0, 2'b01);
        drive(75, 0, 0, 4'b0000, 0, 1, 1, 0, 2'b01);
        drive(76, 0, 0, 4'b0110, 0, 0, 0, 0, 2'b01);

        // Asynchronous reset in the middle of playback
        drive(80, 0, 0, 4'b0000, 0, 0, 1, 1, 2'b11);
        drive(81, 0, 0, 4'b0000, 0, 0, 0, 1, 2'b11);
        drive(82, 0, 0, 4'b0000, 0, 0, 0, 1, 2'b11);
        reset_n = 1'b0;
        model_reset();
        drive(83, 0, 0, 4'b0000, 0, 0, 0, 1, 2'b11);
        reset_n = 1'b1;
        drive(84, 0, 0, 4'b0000, 0, 0, 0, 1, 2'b01);

        // Random traffic
        pe_r = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) pe_r = ~pe_r;
            drive(1000 + i,
                  ($urandom_range(0, 24) == 0),
                  1'($urandom_range(0, 1)),
                  WIDTH'($urandom_range(0, 15)),
                  ($urandom_range(0, 9) < 4),
                  ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 9) < 3),
                  pe_r,
                  2'($urandom_range(0, 3)));
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/simon_datapath_param.md
Name: simon_datapath_param

Overview:
- Parametrised successor to the fixed 4-LED / 64-entry Simon datapath.
- Holds the game pattern memory, the sequence-length and replay counters, level-dependent legality, the LED output mux and a built-in playback tick timer.
- Driven by the Simon control FSM. Adds a full flag, a score display mode and saturating counters, which the first-generation datapath lacks.

Parameters:
- WIDTH, 4: number of buttons/LEDs, i.e. pattern bits.
- DEPTH, 64: maximum sequence length (pattern memory entries); must be a power of two, at least 2.
- ADDR_W, $clog2(DEPTH): memory address width.
- TICKS, 4: clk cycles per playback step; must be at least 1.

Ports:
- clk  input  1  system clock, all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- level  input  1  difficulty select: 0 = easy, 1 = hard. Sampled only on new_game.
- pattern  input  WIDTH  current button pattern from the player.
- new_game  input  1  synchronous game restart; latches level.
- pat_wr  input  1  append pattern to the sequence.
- rep_clr  input  1  clear the replay counter.
- rep_inc  input  1  advance the replay counter.
- play_en  input  1  run the playback timer.
- led_sel  input  2  LED source: 00 pattern, 01 memory, 10 all-on, 11 score.
- is_legal  output  1  pattern is legal for the latched level.
- correct_pattern  output  1  pattern equals mem[rep_cnt].
- is_last_element  output  1  rep_cnt addresses the final stored entry.
- seq_full  output  1  seq_len == DEPTH.
- play_tick  output  1  one-cycle playback step pulse.
- score  output  ADDR_W+1  current seq_len.
- pattern_leds  output  WIDTH  LED drive.

Behaviour:
- State:
  - level_q (1 bit).
  - seq_len (ADDR_W+1 bits, range 0..DEPTH).
  - rep_cnt (ADDR_W bits).
  - timer (range 0..TICKS-1).
  - mem[DEPTH] of WIDTH bits each.
- Async reset (reset_n = 0): level_q = 0, seq_len = 0, rep_cnt = 0, timer = 0, all mem entries = 0. Resulting outputs:
  - is_legal = (pattern one-hot).
  - correct_pattern = (pattern == 0).
  - is_last_element = 0, seq_full = 0, play_tick = 0, score = 0.
  - pattern_leds per led_sel.
- Reset deassertion: takes effect at once. The first rising edge after it is a normal edge.
- new_game (highest priority): level_q <= level, seq_len <= 0, rep_cnt <= 0, timer <= 0. mem is not cleared. pat_wr, rep_clr and rep_inc are ignored that cycle.
- is_legal (combinational):
  - level_q = 1: always 1.
  - level_q = 0: 1 only if pattern has exactly one bit set. All-zero and multi-bit patterns are illegal.
- pat_wr, when is_legal = 1 and seq_full = 0: mem[seq_len[ADDR_W-1:0]] <= pattern, seq_len <= seq_len + 1.
- pat_wr while illegal or full: no state change, no wrap.
- rep_clr: rep_cnt <= 0. It wins over rep_inc in the same cycle.
- rep_inc: rep_cnt <= rep_cnt + 1, saturating at seq_len-1. When seq_len = 0 it stays at 0. It never wraps.
- pat_wr and rep_inc/rep_clr in the same cycle update independently. The rep_inc saturation bound uses the pre-edge seq_len.
- correct_pattern (combinational): pattern == mem[rep_cnt].
- is_last_element (combinational): (seq_len != 0) && (rep_cnt == seq_len-1).
- seq_full (combinational): seq_len == DEPTH.
- score = seq_len.
- Timer:
  - While play_en = 1: timer increments each edge and wraps TICKS-1 -> 0.
  - When play_en = 0: timer <= 0.
  - play_tick = play_en && (timer == TICKS-1), combinational.
  - Result: the first tick arrives TICKS cycles after play_en rises, then one tick every TICKS cycles. TICKS = 1 gives play_tick = play_en.
- pattern_leds (combinational):
  - 00: pattern.
  - 01: mem[rep_cnt].
  - 10: all ones.
  - 11: seq_len zero-extended or truncated to WIDTH bits.
- Latency:
  - All stored results are visible the cycle after the edge.
  - No output is registered except through its state.

Test Plan:
1. Reset and easy-mode legality: reset_n = 0, then 1; level = 0 and new_game pulse; pattern 0100 then 0110 -> is_legal 1 then 0. pat_wr with 0110 -> score stays 0.
2. Hard-mode record and replay: level = 1, new_game; pat_wr with 1111, then 0000 -> score = 2. rep_clr, led_sel = 01 -> leds 1111, is_last_element = 0. rep_inc -> leds 0000, is_last_element = 1. rep_inc again -> rep_cnt stays 1.
3. Compare: hard mode with mem = {1010, 0011}, rep_cnt = 0; pattern 1010 -> correct_pattern = 1; pattern 0011 -> correct_pattern = 0.
4. Full boundary: DEPTH = 4; four legal pat_wr -> seq_full = 1, score = 4. Fifth pat_wr -> mem[0] unchanged, score = 4. led_sel = 11 -> leds 0100.
5. Timer: TICKS = 4; play_en held for 12 cycles -> play_tick high on cycles 4, 8, 12 only. Drop play_en mid-count -> timer clears, no tick.
6. Priority and mid-operation reset:
   - new_game together with pat_wr -> score = 0 and no write.
   - rep_clr together with rep_inc -> rep_cnt = 0.
   - reset_n pulsed low mid-playback -> all counters 0 immediately, without waiting for a clk edge.
